mic_arbiter: RTL and testbench

- Round-robin request arbiter for the memory interface controller (MIC).
- Sits directly upstream of the MIC controller and produces that stage's req_read, req_write, arb_grant and arb_grant_index inputs.
- Captures per-requester read/write requests into sticky pending slots and issues single-cycle grants in round-robin order.
- Grants are issued only while the command FIFO is non-empty, with a programmable minimum gap between grants.

---
 rtl/mic_arbiter.sv | 125 ++++++++++++
 tb/tb_mic_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_arbiter.sv
// Round-robin request arbiter feeding the MIC controller.
// Requests are captured into sticky per-requester pending slots. A single-cycle
// grant is issued in round-robin order while the command FIFO is non-empty.
// Each grant is followed by a programmable number of forced idle cycles.
module mic_arbiter #(
  parameter int NREQS   = 4,
  parameter int NBITS   = (NREQS > 1) ? $clog2(NREQS) : 1,
  parameter int MIN_GAP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQS-1:0] req_valid,
  input  logic [NREQS-1:0] req_is_write,
  input  logic             fifo_empty,
  output logic [NREQS-1:0] req_ack,
  output logic [NREQS-1:0] req_pending,
  output logic             arb_grant,
  output logic [NBITS-1:0] arb_grant_index,
  output logic             req_read,
  output logic             req_write
);

  localparam int unsigned NR = NREQS;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NREQS-1:0] pending;
  logic [NREQS-1:0] wtype;
  logic [NREQS-1:0] capture;
  logic [NREQS-1:0] grant_clr;
  logic [NBITS-1:0] ptr;
  logic [NBITS-1:0] winner;
  logic [NBITS-1:0] win_idx;
  logic             win_type;
  logic             found;
  logic             granting;
  logic [2:0]       gap_cnt;

  assign granting  = (state == GRANT);
  assign grant_clr = granting ? (NREQS'(1) << win_idx) : '0;
  // A slot still pending (including one granted this cycle) cannot recapture.
  assign capture   = req_valid & ~pending;

  // Winner search: lowest pending index at or above the pointer, else wrap to
  // the lowest pending index overall.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!found && pending[i] && (NBITS'(i) >= ptr)) begin
        found  = 1'b1;
        winner = NBITS'(i);
      end
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (!found && pending[i]) begin
        found  = 1'b1;
        winner = NBITS'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; fifo_empty only gates the IDLE to GRANT decision.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if ((|pending) && !fifo_empty) state_nxt = GRANT;
      GRANT:   state_nxt = (MIN_GAP > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt <= 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner latch on grant entry, pointer advance and gap countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_idx  <= '0;
      win_type <= 1'b0;
      ptr      <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == IDLE && state_nxt == GRANT) begin
        win_idx  <= winner;
        win_type <= wtype[winner];
      end
      if (state == GRANT) begin
        ptr     <= (win_idx == NBITS'(NREQS - 1)) ? '0 : win_idx + 1'b1;
        gap_cnt <= 3'(MIN_GAP);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // Pending slots and their request types.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      wtype   <= '0;
    end else begin
      pending <= (pending & ~grant_clr) | capture;
      wtype   <= (wtype & ~capture) | (req_is_write & capture);
    end
  end

  assign arb_grant       = granting;
  assign arb_grant_index = granting ? win_idx : '0;
  assign req_write       = granting & win_type;
  assign req_read        = granting & ~win_type;
  assign req_ack         = grant_clr;
  assign req_pending     = pending;

endmodule

// File: tb/tb_mic_arbiter.sv
// Self-checking bench for mic_arbiter: directed scenarios followed by random
// traffic, all compared against a timestamp-based behavioural model.
module tb_mic_arbiter;

  localparam int N  = 4;
  localparam int NB = 2;
  localparam int G  = 2;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_is_write;
  logic          fifo_empty;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  req_pending;
  logic          arb_grant;
  logic [NB-1:0] arb_grant_index;
  logic          req_read;
  logic          req_write;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: slot contents, pointer, current grant, and the age
  // in cycles since the most recent grant cycle.
  logic [N-1:0] m_pending;
  logic [N-1:0] m_type;
  int           m_ptr;
  int           m_gidx;
  int           m_age;
  logic         m_grant;
  logic         m_wr;

  int g_idx[$];
  int g_wr[$];
  int g_ack[$];
  int g_cyc[$];

  mic_arbiter #(
    .NREQS  (N),
    .NBITS  (NB),
    .MIN_GAP(G)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_is_write   (req_is_write),
    .fifo_empty     (fifo_empty),
    .req_ack        (req_ack),
    .req_pending    (req_pending),
    .arb_grant      (arb_grant),
    .arb_grant_index(arb_grant_index),
    .req_read       (req_read),
    .req_write      (req_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_type    = '0;
    m_ptr     = 0;
    m_gidx    = 0;
    m_age     = 1000;
    m_grant   = 1'b0;
    m_wr      = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    logic [N-1:0] pend;
    logic         ng;
    logic         nw;
    int           ni;
    if (reset) begin
      model_reset();
      return;
    end
    ng = 1'b0;
    nw = 1'b0;
    ni = 0;
    // A decision is possible only once more than G cycles have elapsed since a grant.
    if (m_age > G && m_pending != '0 && !fifo_empty) begin
      ng = 1'b1;
      for (int k = N - 1; k >= 0; k--)
        if (m_pending[(m_ptr + k) % N]) ni = (m_ptr + k) % N;
      nw = m_type[ni];
    end
    pend = m_pending;
    if (m_grant) pend[m_gidx] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!m_pending[i] && req_valid[i]) begin
        pend[i]   = 1'b1;
        m_type[i] = req_is_write[i];
      end
    end
    if (m_grant) m_ptr = (m_gidx + 1) % N;
    m_pending = pend;
    m_grant   = ng;
    m_gidx    = ni;
    m_wr      = nw;
    m_age     = ng ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
  endtask

  task automatic compare_all();
    check("grant",   arb_grant,       m_grant);
    check("index",   arb_grant_index, m_grant ? m_gidx : 0);
    check("write",   req_write,       m_grant & m_wr);
    check("read",    req_read,        m_grant & !m_wr);
    check("ack",     req_ack,         m_grant ? (32'd1 << m_gidx) : 32'd0);
    check("pending", req_pending,     m_pending);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic drain_record(input int n);
    g_idx.delete();
    g_wr.delete();
    g_ack.delete();
    g_cyc.delete();
    for (int i = 0; i < n; i++) begin
      tick();
      if (arb_grant) begin
        g_idx.push_back(int'(arb_grant_index));
        g_wr.push_back(int'(req_write));
        g_ack.push_back(int'(req_ack));
        g_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    check("rst_grant",   arb_grant,              0);
    check("rst_pending", req_pending,            0);
    check("rst_ack",     req_ack,                0);
    check("rst_rw",      {req_read, req_write},  0);
    check("rst_index",   arb_grant_index,        0);
    model_reset();
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '1;
    req_is_write = '0;
    fifo_empty   = 1'b0;
    model_reset();
    #2;

    // Reset held with all requests active: outputs stay at zero.
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    tick();
    check("first_grant",     arb_grant,       1);
    check("first_grant_idx", arb_grant_index, 0);
    req_valid = '0;
    drain_record(20);

    // Round robin over all four requesters.
    req_valid    = 4'b1111;
    req_is_write = 4'b0101;
    tick();
    req_valid = '0;
    drain_record(20);
    check("rr_count", g_idx.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < g_idx.size()) begin
        check("rr_idx", g_idx[k], k);
        check("rr_wr",  g_wr[k],  (k % 2 == 0) ? 1 : 0);
        check("rr_ack", g_ack[k], 1 << k);
        if (k > 0) check("rr_spacing", g_cyc[k] - g_cyc[k-1], G + 2);
      end
    end

    // FIFO gating.
    fifo_empty = 1'b1;
    req_valid  = 4'b0100;
    tick();
    req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
    check("gate_pending", req_pending, 4'b0100);
    fifo_empty = 1'b0;
    tick();
    check("gate_grant",     arb_grant,       1);
    check("gate_grant_idx", arb_grant_index, 2);
    drain_record(6);

    // Pointer wrap: grant 3 first, then 1001 must go 0 then 3.
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    drain_record(8);
    req_valid = 4'b1001;
    tick();
    req_valid = '0;
    drain_record(12);
    check("wrap_count", g_idx.size(), 2);
    if (g_idx.size() == 2) begin
      check("wrap_first",  g_idx[0], 0);
      check("wrap_second", g_idx[1], 3);
    end

    // Duplicate request while pending: type is not overwritten.
    fifo_empty   = 1'b1;
    req_valid    = 4'b0010;
    req_is_write = 4'b0000;
    tick();
    req_is_write = 4'b0010;
    tick();
    req_valid  = '0;
    fifo_empty = 1'b0;
    drain_record(10);
    check("dup_count", g_idx.size(), 1);
    if (g_idx.size() == 1) begin
      check("dup_idx", g_idx[0], 1);
      check("dup_wr",  g_wr[0],  0);
    end

    // Reset during GAP with requests still pending.
    fifo_empty = 1'b1;
    req_valid  = 4'b1010;
    tick();
    req_valid  = '0;
    fifo_empty = 1'b0;
    tick();
    check("gapr_grant", arb_grant, 1);
    tick();
    check("gapr_pending_before", req_pending != 0, 1);
    async_reset();
    tick();
    reset = 1'b0;
    drain_record(10);
    check("gapr_no_grant", g_idx.size(), 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      req_valid    = N'($urandom & $urandom);
      req_is_write = N'($urandom);
      fifo_empty   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
